// File: rtl/if_dec_queue.sv
// rtl/if_dec_queue.sv - fetch-to-decode instruction queue with exception lock
module if_dec_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 40,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [ADDR_W-1:0]          fetch_pc,
  input  logic [INST_W-1:0]          fetch_inst,
  input  logic                       fetch_xcpt_misaligned,
  input  logic                       fetch_xcpt_if,
  output logic                       fetch_ready,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [ADDR_W-1:0]          dec_pc,
  output logic [INST_W-1:0]          dec_inst,
  output logic                       dec_xcpt,
  output logic [1:0]                 dec_xcpt_cause,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

  typedef enum logic {RUN = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t state_q, state_d;

  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [INST_W-1:0] mem_inst  [DEPTH];
  logic              mem_xcpt  [DEPTH];
  logic [1:0]        mem_cause [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, xcpt_lock;
  logic             push, pop, xcpt_in;
  logic [1:0]       cause_in;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign xcpt_lock = (state_q == LOCKED);

  // Ready never looks at dec_ready: a full queue refuses a push even when a pop is in flight.
  assign fetch_ready = ~full & ~xcpt_lock & ~rst;
  assign dec_valid   = ~empty;
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign pop         = dec_valid & dec_ready & ~flush;

  // Misaligned wins when both fault flags are raised.
  assign xcpt_in  = fetch_xcpt_misaligned | fetch_xcpt_if;
  assign cause_in = fetch_xcpt_misaligned ? 2'b01 :
                    (fetch_xcpt_if ? 2'b10 : 2'b00);

  // Head is read straight from storage; empty queue reads as all zeros.
  assign dec_pc         = empty ? '0 : mem_pc[rd_ptr];
  assign dec_inst       = empty ? '0 : mem_inst[rd_ptr];
  assign dec_xcpt       = empty ? 1'b0 : mem_xcpt[rd_ptr];
  assign dec_xcpt_cause = empty ? 2'b00 : mem_cause[rd_ptr];

  // Entry storage; a faulting fetch is stored as a NOP so decode never sees garbage bits.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_inst[wr_ptr]  <= xcpt_in ? NOP_INST : fetch_inst;
      mem_xcpt[wr_ptr]  <= xcpt_in;
      mem_cause[wr_ptr] <= cause_in;
    end
  end

  // Pointers and occupancy; flush and reset both empty the queue and rewind to slot 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Lock next-state: an exception push locks, only a flush unlocks (push is already masked by flush).
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (push && xcpt_in) state_d = LOCKED;
      LOCKED:  if (flush)           state_d = RUN;
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_if_dec_queue.sv
// tb/tb_if_dec_queue.sv - directed vector bench for if_dec_queue
module tb_if_dec_queue;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_xcpt_misaligned, fetch_xcpt_if, dec_ready;
  logic [39:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_ready, dec_valid, dec_xcpt;
  logic [39:0] dec_pc;
  logic [31:0] dec_inst;
  logic [1:0]  dec_xcpt_cause;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  if_dec_queue #(.DEPTH(4), .ADDR_W(40), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_xcpt_misaligned(fetch_xcpt_misaligned), .fetch_xcpt_if(fetch_xcpt_if),
    .fetch_ready(fetch_ready), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_xcpt(dec_xcpt),
    .dec_xcpt_cause(dec_xcpt_cause), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, fv;
    logic [39:0] pc;
    logic [31:0] inst;
    logic        mis, fif, dr;
    logic        e_fr, e_dv;
    logic [39:0] e_pc;
    logic [31:0] e_inst;
    logic        e_xc;
    logic [1:0]  e_cause;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic fv, input logic [39:0] pc, input logic [31:0] inst,
                     input logic mis, input logic fif, input logic dr,
                     input logic e_fr, input logic e_dv, input logic [39:0] e_pc,
                     input logic [31:0] e_inst, input logic e_xc, input logic [1:0] e_cause,
                     input logic [2:0] e_cnt);
    vec_t v;
    v.flush = fl; v.fv = fv; v.pc = pc; v.inst = inst; v.mis = mis; v.fif = fif; v.dr = dr;
    v.e_fr = e_fr; v.e_dv = e_dv; v.e_pc = e_pc; v.e_inst = e_inst; v.e_xc = e_xc;
    v.e_cause = e_cause; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic fl, input logic fv, input logic [39:0] pc, input logic [31:0] inst,
                     input logic mis, input logic fif, input logic dr);
    flush = fl; fetch_valid = fv; fetch_pc = pc; fetch_inst = inst;
    fetch_xcpt_misaligned = mis; fetch_xcpt_if = fif; dec_ready = dr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic fr, input logic dv, input logic [39:0] pc,
                          input logic [31:0] inst, input logic xc, input logic [1:0] cause,
                          input logic [2:0] cnt);
    chk({tag, ".fetch_ready"}, 64'(fetch_ready), 64'(fr));
    chk({tag, ".dec_valid"},   64'(dec_valid),   64'(dv));
    chk({tag, ".dec_pc"},      64'(dec_pc),      64'(pc));
    chk({tag, ".dec_inst"},    64'(dec_inst),    64'(inst));
    chk({tag, ".dec_xcpt"},    64'(dec_xcpt),    64'(xc));
    chk({tag, ".cause"},       64'(dec_xcpt_cause), 64'(cause));
    chk({tag, ".count"},       64'(count),       64'(cnt));
  endtask

  initial begin
    //   fl fv pc          inst          mis fif dr | fr dv e_pc        e_inst        xc cs cnt
    // fill to full, fifth push ignored, then drain in order
    add(0, 1, 'h1000, 'hA0, 0, 0, 0,   1, 1, 'h1000, 'hA0, 0, 0, 1);
    add(0, 1, 'h1004, 'hA1, 0, 0, 0,   1, 1, 'h1000, 'hA0, 0, 0, 2);
    add(0, 1, 'h1008, 'hA2, 0, 0, 0,   1, 1, 'h1000, 'hA0, 0, 0, 3);
    add(0, 1, 'h100C, 'hA3, 0, 0, 0,   0, 1, 'h1000, 'hA0, 0, 0, 4);
    add(0, 1, 'h1010, 'hA4, 0, 0, 0,   0, 1, 'h1000, 'hA0, 0, 0, 4);
    add(0, 0, 'h0,    'h0,  0, 0, 1,   1, 1, 'h1004, 'hA1, 0, 0, 3);
    add(0, 0, 'h0,    'h0,  0, 0, 1,   1, 1, 'h1008, 'hA2, 0, 0, 2);
    add(0, 0, 'h0,    'h0,  0, 0, 1,   1, 1, 'h100C, 'hA3, 0, 0, 1);
    add(0, 0, 'h0,    'h0,  0, 0, 1,   1, 0, 'h0,    'h0,  0, 0, 0);
    // fetch fault: NOP stored, lock until flush
    add(0, 1, 'h2000, 'hDEADBEEF, 0, 1, 0, 0, 1, 'h2000, 'h13, 1, 2, 1);
    add(0, 1, 'h2004, 'h1,  0, 0, 0,   0, 1, 'h2000, 'h13, 1, 2, 1);
    add(1, 1, 'h2008, 'h2,  0, 0, 0,   1, 0, 'h0,    'h0,  0, 0, 0);
    // both fault flags: misaligned wins
    add(0, 1, 'h2100, 'h5,  1, 1, 0,   0, 1, 'h2100, 'h13, 1, 1, 1);
    add(1, 0, 'h0,    'h0,  0, 0, 0,   1, 0, 'h0,    'h0,  0, 0, 0);
    // three entries then flush with push and pop together
    add(0, 1, 'h4000, 'h40, 0, 0, 0,   1, 1, 'h4000, 'h40, 0, 0, 1);
    add(0, 1, 'h4004, 'h41, 0, 0, 0,   1, 1, 'h4000, 'h40, 0, 0, 2);
    add(0, 1, 'h4008, 'h42, 0, 0, 0,   1, 1, 'h4000, 'h40, 0, 0, 3);
    add(1, 1, 'h400C, 'h43, 0, 0, 1,   1, 0, 'h0,    'h0,  0, 0, 0);
    add(0, 1, 'h5000, 'h50, 0, 0, 0,   1, 1, 'h5000, 'h50, 0, 0, 1);
    // flush beats an exception push in the same cycle: no lock
    add(1, 1, 'h5004, 'h51, 0, 1, 0,   1, 0, 'h0,    'h0,  0, 0, 0);
    add(0, 1, 'h5008, 'h58, 0, 0, 0,   1, 1, 'h5008, 'h58, 0, 0, 1);
    // push and pop at count 1 replaces the head
    add(0, 1, 'h500C, 'h59, 0, 0, 1,   1, 1, 'h500C, 'h59, 0, 0, 1);
    add(0, 0, 'h0,    'h0,  0, 0, 1,   1, 0, 'h0,    'h0,  0, 0, 0);

    // reset: ready low during the reset cycle, reset values afterwards
    rst = 1'b1;
    drv(0, 0, '0, '0, 0, 0, 0);
    #1;
    chk("rst_cycle.fetch_ready", 64'(fetch_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk_outs("after_rst", 1, 0, '0, '0, 0, 2'b00, 3'd0);

    // no same-cycle pass-through
    drv(0, 1, 40'h777, 32'h77, 0, 0, 0);
    #1;
    chk("no_bypass.dec_valid", 64'(dec_valid), 64'd0);
    drv(0, 0, '0, '0, 0, 0, 0);
    #1;

    foreach (vecs[i]) begin
      drv(vecs[i].flush, vecs[i].fv, vecs[i].pc, vecs[i].inst, vecs[i].mis, vecs[i].fif, vecs[i].dr);
      step();
      chk_outs($sformatf("v%0d", i), vecs[i].e_fr, vecs[i].e_dv, vecs[i].e_pc, vecs[i].e_inst,
               vecs[i].e_xc, vecs[i].e_cause, vecs[i].e_cnt);
    end

    // streaming across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      drv(0, 1, 40'h3000 + 40'(4 * i), 32'h300 + 32'(i), 0, 0, 1);
      step();
      chk_outs($sformatf("stream%0d", i), 1, 1, 40'h3000 + 40'(4 * i), 32'h300 + 32'(i), 0, 2'b00, 3'd1);
    end
    drv(0, 0, '0, '0, 0, 0, 1);
    step();
    chk("stream_end.count", 64'(count), 64'd0);

    // reset mid-stream with three entries and the lock set
    drv(0, 1, 40'h6100, 32'h61, 0, 0, 0); step();
    drv(0, 1, 40'h6104, 32'h62, 0, 0, 0); step();
    drv(0, 1, 40'h6108, 32'h63, 1, 0, 0); step();
    chk_outs("pre_rst", 0, 1, 40'h6100, 32'h61, 0, 2'b00, 3'd3);
    drv(0, 1, 40'h610C, 32'h64, 0, 0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst.fetch_ready", 64'(fetch_ready), 64'd0);
    step();
    rst = 1'b0;
    drv(0, 0, '0, '0, 0, 0, 0);
    #1;
    chk_outs("post_rst", 1, 0, '0, '0, 0, 2'b00, 3'd0);
    drv(0, 1, 40'h6000, 32'h60, 0, 0, 0);
    step();
    chk_outs("post_rst_push", 1, 1, 40'h6000, 32'h60, 0, 2'b00, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
